gps_uart_rx: RTL and testbench
==============================

Name: gps_uart_rx

Overview:
- Asynchronous serial (8N1) byte receiver sitting directly upstream of GpsReceiver.
- Converts the GPS module's NMEA line (idle-high, LSB-first) into a byte bus plus a one-cycle load strobe.
- data connects to GpsReceiver.data and load to GpsReceiver.load, so the parser advances exactly once per received character.

Parameters:
- B, 8: data bits per frame; equals the byte width on the GpsReceiver data bus.
- CLKS_PER_BIT, 5208: clock cycles per serial bit (50 MHz / 9600 baud). Legal range is 4 or more. The bench uses 16.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rxd  in  1  raw serial line, asynchronous to clock, idle high.
- data  out  B  last correctly framed byte; holds its value between frames.
- load  out  1  one-cycle strobe; data is valid in the same cycle.
- frame_error  out  1  one-cycle strobe when the stop bit is sampled low.
- busy  out  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset: data=0, load=0, frame_error=0, busy=0, state=IDLE, both synchroniser flops=1, bit counter=0, cycle counter=0.
- Synchroniser: 2-flop, rx_s = second flop. rx_s lags rxd by 2 cycles.
- Timing origin T0: the first cycle in which rx_s==0 while in IDLE. All sample points below are relative to T0.
- Cycle counter width is $clog2(CLKS_PER_BIT).
- IDLE: busy=0. If rx_s==0 -> START, counter cleared, busy=1.
- START: sample rx_s at T0+CLKS_PER_BIT/2 (integer divide).
  - 0 -> DATA.
  - 1 -> glitch; return to IDLE, no strobes.
- DATA: sample bit i (i=0..B-1) at T0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT.
  - Shift into the shift register, LSB first.
  - After bit B-1 -> STOP.
- STOP: sample at T0+CLKS_PER_BIT/2+(B+1)*CLKS_PER_BIT.
  - 1 -> data<=shift register, load=1 in the next cycle, -> IDLE.
  - 0 -> frame_error=1 in the next cycle, data unchanged, -> WAIT_IDLE.
- WAIT_IDLE: busy=1. Stay until rx_s==1, then -> IDLE. Covers break conditions and line-low faults.
- Output rules:
  - load and frame_error are never both high.
  - Each is high for exactly one cycle per frame.
  - data changes only in the cycle load rises.
- Back-to-back frames: IDLE is re-entered mid stop bit, so a start edge arriving immediately after the stop bit is accepted with no lost byte.
- Reset mid-frame: the next cycle shows reset values. The partial byte is discarded, with no load and no frame_error.
- Simultaneous reset and stop-sample: reset wins, no strobe.
- Latency for CLKS_PER_BIT=16, B=8:
  - stop sample at T0+152, load high at T0+153;
  - relative to the rxd falling edge, add 2 cycles.

Decomposition:
- Shared include file gps_defs.vh holds:
  - state encoding localparams (IDLE, START, DATA, STOP, WAIT_IDLE);
  - the byte width B=8;
  - the idle line level;
  - the default CLKS_PER_BIT.
- One natural sub-module: sync_2ff (parameterised reset value, here 1). GpsReceiver can reuse it.
- The FSM and counters stay in gps_uart_rx.

Test Plan:
- Single byte 8'h24 ('$'), CLKS_PER_BIT=16 -> load high exactly at T0+153 for one cycle, data=8'h24, frame_error stays 0, busy falls at T0+153.
- Full sentence "$GPZDA,143042.00,25,08,2005,,*6E" sent back-to-back (no idle gap), output into GpsReceiver -> 32 load pulses, bytes match in order, no frame_error, GpsReceiver accepts the sentence.
- Glitch: rxd low for 4 cycles then high -> START sample reads 1, state returns to IDLE at T0+9, no load, no frame_error, data unchanged.
- Framing error: byte 8'h55 with stop bit 0 -> frame_error pulse at T0+153, no load, data keeps previous 8'h24. Line then high and byte 8'h41 sent -> load with data=8'h41.
- Break: rxd held low 400 cycles -> exactly one frame_error pulse, busy high until 2 cycles after rxd rises. The next byte 8'h2A is received correctly.
- Reset pulse during data bit 3 of byte 8'hFF -> all outputs 0 the following cycle, no strobe. The subsequent frame 8'h36 -> load with data=8'h36.

Source files
------------

// File: rtl/gps_uart_rx_pkg.sv
// gps_uart_rx_pkg: shared constants for the GPS serial receive path.
package gps_uart_rx_pkg;
  localparam int BYTE_W = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 5208;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;
endpackage

// File: rtl/gps_uart_rx_sync_2ff.sv
// sync_2ff: two-flop synchroniser with a configurable reset level.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/gps_uart_rx.sv
// gps_uart_rx: 8N1 serial byte receiver feeding GpsReceiver with data plus a load strobe.
module gps_uart_rx
  import gps_uart_rx_pkg::*;
#(
  parameter int B = BYTE_W,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         rxd,
  output logic [B-1:0] data,
  output logic         load,
  output logic         frame_error,
  output logic         busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(B - 1);
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [B-1:0]  shift;
  sync_2ff #(.RESET_VALUE(IDLE_LEVEL)) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (rxd),
    .q    (rx_s)
  );
  assign busy = state != S_IDLE;
  // Counter restarts at every sample so each wait is measured from the previous sample point.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      data        <= '0;
      load        <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      load        <= 1'b0;
      frame_error <= 1'b0;
      cnt         <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (rx_s != IDLE_LEVEL) state <= S_START;
        end
        S_START: if (cnt == HALF_M1) begin
          cnt   <= '0;
          state <= (rx_s == IDLE_LEVEL) ? S_IDLE : S_DATA;
        end
        S_DATA: if (cnt == LAST) begin
          cnt     <= '0;
          shift   <= {rx_s, shift[B-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state <= S_STOP;
        end
        // Leaving mid stop bit lets a start edge right after the stop bit be caught.
        S_STOP: if (cnt == LAST) begin
          cnt <= '0;
          if (rx_s == IDLE_LEVEL) begin
            data  <= shift;
            load  <= 1'b1;
            state <= S_IDLE;
          end else begin
            frame_error <= 1'b1;
            state       <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s == IDLE_LEVEL) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gps_uart_rx.sv
// tb_gps_uart_rx: directed self-checking bench for gps_uart_rx at 16 clocks per bit.
module tb_gps_uart_rx;
  localparam int CPB = 16;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       load, frame_error, busy;
  int cyc = 0, tests = 0, fails = 0;
  int load_cnt = 0, fe_cnt = 0, both = 0;
  int load_cyc = -1, fe_cyc = -1, busy_fall_cyc = -1, fall = 0;
  logic prev_busy = 1'b0;
  logic [7:0] got[$];

  gps_uart_rx #(.B(8), .CLKS_PER_BIT(CPB)) dut (
    .clock      (clock),
    .reset      (reset),
    .rxd        (rxd),
    .data       (data),
    .load       (load),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (load === 1'b1) begin
      load_cnt++;
      load_cyc = cyc;
      got.push_back(data);
    end
    if (frame_error === 1'b1) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (load === 1'b1 && frame_error === 1'b1) both++;
    if (prev_busy === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
    prev_busy = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put_bit(input logic v);
    rxd = v;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    fall = cyc;
    put_bit(1'b0);
    for (int i = 0; i < 8; i++) put_bit(b[i]);
    put_bit(stop);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int lc, fc;
    string s;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_data", data, 8'h00);
    chk("rst_load", load, 1'b0);
    chk("rst_fe", frame_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    idle(10);

    send_frame(8'h24, 1'b1);
    idle(5);
    chk("b24_load_cyc", load_cyc, fall + 155);
    chk("b24_load_cnt", load_cnt, 1);
    chk("b24_data", data, 8'h24);
    chk("b24_fe_cnt", fe_cnt, 0);
    chk("b24_busy_fall", busy_fall_cyc, fall + 155);

    fall = cyc;
    rxd = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    idle(40);
    chk("glitch_busy_fall", busy_fall_cyc, fall + 11);
    chk("glitch_load_cnt", load_cnt, 1);
    chk("glitch_fe_cnt", fe_cnt, 0);
    chk("glitch_data", data, 8'h24);

    send_frame(8'h55, 1'b0);
    idle(20);
    chk("fe_cyc", fe_cyc, fall + 155);
    chk("fe_cnt", fe_cnt, 1);
    chk("fe_load_cnt", load_cnt, 1);
    chk("fe_data_kept", data, 8'h24);
    send_frame(8'h41, 1'b1);
    idle(5);
    chk("b41_load_cyc", load_cyc, fall + 155);
    chk("b41_data", data, 8'h41);

    fc = fe_cnt;
    rxd = 1'b0;
    repeat (400) @(posedge clock);
    #1;
    chk("brk_busy_low_line", busy, 1'b1);
    chk("brk_fe_once", fe_cnt, fc + 1);
    fall = cyc;
    idle(10);
    chk("brk_busy_fall", busy_fall_cyc, fall + 3);
    send_frame(8'h2A, 1'b1);
    idle(5);
    chk("b2a_data", data, 8'h2A);
    chk("b2a_load_cyc", load_cyc, fall + 155);

    lc = load_cnt;
    fc = fe_cnt;
    put_bit(1'b0);
    for (int i = 0; i < 3; i++) put_bit(1'b1);
    rxd = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    chk("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_load", load, 1'b0);
    chk("mid_rst_fe", frame_error, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    reset = 1'b0;
    idle(200);
    chk("mid_rst_no_load", load_cnt, lc);
    chk("mid_rst_no_fe", fe_cnt, fc);
    send_frame(8'h36, 1'b1);
    idle(5);
    chk("b36_data", data, 8'h36);
    chk("b36_load_cnt", load_cnt, lc + 1);

    s = "$GPZDA,143042.00,25,08,2005,,*6E";
    got.delete();
    lc = load_cnt;
    fc = fe_cnt;
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1);
    idle(5);
    chk("nmea_load_cnt", load_cnt, lc + 32);
    chk("nmea_fe_cnt", fe_cnt, fc);
    chk("nmea_q_size", got.size(), 32);
    for (int i = 0; i < s.len() && i < got.size(); i++)
      chk($sformatf("nmea_byte%0d", i), got[i], s[i]);
    chk("never_both", both, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
